// File: rtl/serial_rx_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_receiver.sv
// Frames a bit_valid-qualified serial stream (start, N data MSB first, optional even parity,
// stop) and presents each word on a one-deep valid/ready buffer with error and overrun status.
module serial_frame_receiver
  import serial_rx_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bit_valid,
  input  logic         serial_in,
  input  logic         out_ready,
  input  logic         clr_overrun,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output logic         out_parity_err,
  output logic         out_frame_err,
  output logic         overrun,
  output logic         busy
);

  localparam int unsigned CntW = $clog2(N) + 1;

  rx_state_t       state;
  logic [CntW-1:0] bit_cnt;
  logic [N-1:0]    shift;
  logic            par_acc;
  logic            perr;
  logic            slot_free;

  assign busy      = (state != IDLE);
  // The buffer can take a new word if it is empty or being drained this very edge.
  assign slot_free = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shift          <= '0;
      par_acc        <= 1'b0;
      perr           <= 1'b0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_parity_err <= 1'b0;
      out_frame_err  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (clr_overrun) overrun <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (bit_valid) begin
        unique case (state)
          IDLE: begin
            if (serial_in == START_BIT) begin
              state   <= DATA;
              bit_cnt <= '0;
              par_acc <= 1'b0;
              perr    <= 1'b0;
            end
          end
          DATA: begin
            shift   <= {shift[N-2:0], serial_in};
            par_acc <= par_acc ^ serial_in;
            bit_cnt <= bit_cnt + CntW'(1);
            if (bit_cnt == CntW'(N - 1)) begin
              if (PARITY_EN) state <= PARITY;
              else           state <= STOP;
            end
          end
          PARITY: begin
            perr  <= par_acc ^ serial_in;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            // Later assignments override the accept-clear and overrun-clear above.
            if (slot_free) begin
              out_data       <= shift;
              out_parity_err <= perr;
              out_frame_err  <= (serial_in != STOP_BIT);
              out_valid      <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Randomized scoreboard bench for serial_frame_receiver with a transaction-level reference model.
module tb_serial_frame_receiver;

  localparam int PH_MID   = 0;
  localparam int PH_START = 1;
  localparam int PH_STOP  = 2;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_valid = 1'b0, serial_in = 1'b0, out_ready = 1'b0, clr_overrun = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_parity_err, out_frame_err, overrun, busy;

  logic       bv1 = 1'b0, si1 = 1'b0;
  logic [7:0] out_data1;
  logic       out_valid1, out_parity_err1, out_frame_err1, overrun1, busy1;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   rmode = 0;
  int   clr_rate = 0;
  exp_t q[$];
  exp_t cur;
  logic m_full = 1'b0, m_ovr = 1'b0, m_busy = 1'b0;

  always #5 clk = ~clk;

  serial_frame_receiver #(.N(8), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .serial_in(serial_in),
    .out_ready(out_ready), .clr_overrun(clr_overrun), .out_data(out_data),
    .out_valid(out_valid), .out_parity_err(out_parity_err), .out_frame_err(out_frame_err),
    .overrun(overrun), .busy(busy)
  );

  serial_frame_receiver #(.N(8), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .bit_valid(bv1), .serial_in(si1),
    .out_ready(1'b0), .clr_overrun(1'b0), .out_data(out_data1),
    .out_valid(out_valid1), .out_parity_err(out_parity_err1), .out_frame_err(out_frame_err1),
    .overrun(overrun1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: buffer status every cycle, word contents whenever the consumer takes one.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h, expected none at %0t", out_data, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_data", {24'd0, out_data}, {24'd0, e.d});
          check("parity_err", {31'd0, out_parity_err}, {31'd0, e.pe});
          check("frame_err", {31'd0, out_frame_err}, {31'd0, e.fe});
        end
      end
    end
  end

  // One clock of stimulus; the model advances at the same edge the DUT samples.
  task automatic tick_ctl(input logic bv, input logic si, input int ph, input logic rdy,
                          input logic clr);
    logic was_full;
    bit_valid = bv; serial_in = si; out_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    if (!rst_n) begin
      m_full = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
      q.delete();
    end else begin
      was_full = m_full;
      if (clr) m_ovr = 1'b0;
      if (was_full && rdy) m_full = 1'b0;
      if (bv && ph == PH_START) m_busy = 1'b1;
      if (bv && ph == PH_STOP) begin
        m_busy = 1'b0;
        if (!was_full || rdy) begin
          q.push_back(cur);
          m_full = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic tick(input logic bv, input logic si, input int ph);
    logic rdy, clr;
    rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
    clr = (clr_rate != 0) && ($urandom_range(0, clr_rate - 1) == 0);
    tick_ctl(bv, si, ph, rdy, clr);
  endtask

  task automatic send_bit(input logic si, input int ph, input int gmode);
    int gaps;
    gaps = (gmode == 1) ? 1 : (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < gaps; g++) tick(1'b0, 1'($urandom_range(0, 1)), PH_MID);
    tick(1'b1, si, ph);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pinj, input logic sbit,
                            input int gmode);
    logic pbit;
    pbit   = (($countones(d) % 2) == 1) ^ pinj;
    cur.d  = d;
    cur.pe = (($countones(d) + int'(pbit)) % 2) != 0;
    cur.fe = sbit;
    send_bit(1'b1, PH_START, gmode);
    for (int i = 7; i >= 0; i--) send_bit(d[i], PH_MID, gmode);
    send_bit(pbit, PH_MID, gmode);
    send_bit(sbit, PH_STOP, gmode);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] np_word;
    rst_n = 1'b0;
    tick_ctl(1'b0, 1'b0, PH_MID, 1'b0, 1'b0);
    tick_ctl(1'b0, 1'b0, PH_MID, 1'b0, 1'b0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_errs", {30'd0, out_parity_err, out_frame_err}, 32'd0);
    check("rst_ovr_busy", {30'd0, overrun, busy}, 32'd0);
    rst_n = 1'b1;

    rmode = 0;
    tick(1'b1, 1'b0, PH_MID);
    send_frame(8'hA5, 1'b0, 1'b0, 0);
    tick(1'b1, 1'b0, PH_MID);
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    tick(1'b0, 1'b0, PH_MID);

    // Backpressure: second frame must be dropped and flagged.
    rmode = 1;
    send_frame(8'h11, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, PH_MID);
    check("bp_data", {24'd0, out_data}, 32'h11);
    check("bp_state", {29'd0, out_valid, overrun, busy}, 32'b110);
    tick_ctl(1'b0, 1'b0, PH_MID, 1'b1, 1'b0);
    tick_ctl(1'b0, 1'b0, PH_MID, 1'b0, 1'b1);
    check("ovr_clear", {31'd0, overrun}, 32'd0);

    rmode = 0;
    send_frame(8'hC3, 1'b0, 1'b0, 1);
    tick(1'b0, 1'b0, PH_MID);

    // Mid-frame reset: start + 4 data bits, then one reset edge.
    tick(1'b1, 1'b1, PH_START);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'($urandom_range(0, 1)), PH_MID);
    rst_n = 1'b0;
    tick_ctl(1'b0, 1'b0, PH_MID, 1'b0, 1'b0);
    rst_n = 1'b1;
    check("mid_rst_out", {22'd0, out_data, out_valid, out_parity_err}, 32'd0);
    check("mid_rst_busy", {29'd0, out_frame_err, overrun, busy}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, PH_MID);

    // Randomized traffic: random words, errors, gaps, backpressure and overrun clears.
    rmode = 2;
    clr_rate = 8;
    for (int f = 0; f < 40; f++) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) tick(1'($urandom_range(0, 1)), 1'b0, PH_MID);
      send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 2);
    end
    rmode = 0;
    clr_rate = 0;
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, PH_MID);
    check("drain", q.size(), 32'd0);

    // No-parity variant: start, 8 data bits, stop with no parity slot.
    np_word = 8'hFF;
    bv1 = 1'b1;
    si1 = 1'b1;
    @(posedge clk); #1;
    for (int i = 7; i >= 0; i--) begin
      si1 = np_word[i];
      @(posedge clk); #1;
    end
    check("np_pre_stop", {30'd0, busy1, out_valid1}, 32'b10);
    si1 = 1'b0;
    @(posedge clk); #1;
    bv1 = 1'b0;
    check("np_data", {24'd0, out_data1}, 32'hFF);
    check("np_flags", {28'd0, out_valid1, out_parity_err1, out_frame_err1, busy1}, 32'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
